mc_control: RTL and testbench

Multicycle control unit for the CPU. It sequences each instruction through fetch, decode, execute, memory and write-back states. From the latched instruction fields it drives the ALU operation code and all datapath enables, and it stalls on a memory-ready handshake. It sits beside the multicycle datapath and drives the ALU's 4-bit `aluc` select.

---
 rtl/mc_control.sv | 190 +++++++++++++++++++
 tb/tb_mc_control.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multicycle CPU control unit: sequences IF/ID/EXE/MEM/WB and decodes the
// latched instruction into ALU select and datapath enables.
//
// state | meaning
// IF    | fetch; waits on mem_ready, loads IR and PC+4 when it arrives
// ID    | decode; jumps and illegal encodings finish here
// EXE   | ALU operation; branches resolve and finish here
// MEM   | data access for lw/sw at the ALU address; waits on mem_ready
// WB    | register-file write from ALU result or memory data

module mc_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       pcwrite,
    output logic [1:0] pcsource,
    output logic       irwrite,
    output logic       iord,
    output logic       wmem,
    output logic       wreg,
    output logic       m2reg,
    output logic       regrt,
    output logic       aluimm,
    output logic       sext,
    output logic       shift,
    output logic [3:0] aluc,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_LUI  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1111;
    localparam logic [3:0] ALU_HAMD = 4'b1011;

    state_t     r_state;
    state_t     w_next;
    logic       w_rtype;
    logic       w_legal;
    logic [3:0] w_aluc;
    logic       w_imm;
    logic       w_sext;
    logic       w_shift;
    logic       w_lw;
    logic       w_sw;
    logic       w_beq;
    logic       w_bne;
    logic       w_j;

    assign w_rtype = (op == 6'b000000);

    always_comb begin
        w_legal = 1'b1;
        w_aluc  = ALU_ADD;
        w_imm   = 1'b0;
        w_sext  = 1'b0;
        w_shift = 1'b0;
        w_lw    = 1'b0;
        w_sw    = 1'b0;
        w_beq   = 1'b0;
        w_bne   = 1'b0;
        w_j     = 1'b0;
        case (op)
            6'b000000: begin
                case (func)
                    6'b100000: w_aluc = ALU_ADD;
                    6'b100010: w_aluc = ALU_SUB;
                    6'b100100: w_aluc = ALU_AND;
                    6'b100101: w_aluc = ALU_OR;
                    6'b100110: w_aluc = ALU_XOR;
                    6'b000000: begin w_aluc = ALU_SLL; w_shift = 1'b1; end
                    6'b000010: begin w_aluc = ALU_SRL; w_shift = 1'b1; end
                    6'b000011: begin w_aluc = ALU_SRA; w_shift = 1'b1; end
                    6'b111111: w_aluc = ALU_HAMD;
                    default:   w_legal = 1'b0;
                endcase
            end
            6'b001000: begin w_aluc = ALU_ADD; w_imm = 1'b1; w_sext = 1'b1; end
            6'b001100: begin w_aluc = ALU_AND; w_imm = 1'b1; end
            6'b001101: begin w_aluc = ALU_OR;  w_imm = 1'b1; end
            6'b001110: begin w_aluc = ALU_XOR; w_imm = 1'b1; end
            6'b001111: begin w_aluc = ALU_LUI; w_imm = 1'b1; end
            6'b100011: begin w_aluc = ALU_ADD; w_imm = 1'b1; w_sext = 1'b1; w_lw = 1'b1; end
            6'b101011: begin w_aluc = ALU_ADD; w_imm = 1'b1; w_sext = 1'b1; w_sw = 1'b1; end
            6'b000100: begin w_aluc = ALU_SUB; w_beq = 1'b1; end
            6'b000101: begin w_aluc = ALU_SUB; w_bne = 1'b1; end
            6'b000010: w_j = 1'b1;
            default:   w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF:    w_next = mem_ready ? S_ID : S_IF;
            S_ID:    w_next = (w_j || !w_legal) ? S_IF : S_EXE;
            S_EXE: begin
                if (w_beq || w_bne)    w_next = S_IF;
                else if (w_lw || w_sw) w_next = S_MEM;
                else                   w_next = S_WB;
            end
            S_MEM:   w_next = mem_ready ? (w_lw ? S_WB : S_IF) : S_MEM;
            S_WB:    w_next = S_IF;
            default: w_next = S_IF;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IF;
        else       r_state <= w_next;
    end

    // Reset masks every output in the same cycle, so an abandoned access writes nothing.
    always_comb begin
        state    = reset ? 3'd0 : r_state;
        pcwrite  = 1'b0;
        pcsource = 2'b00;
        irwrite  = 1'b0;
        iord     = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        m2reg    = 1'b0;
        regrt    = 1'b0;
        aluimm   = 1'b0;
        sext     = 1'b0;
        shift    = 1'b0;
        aluc     = 4'b0000;
        illegal  = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IF: begin
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_ID: begin
                    if (!w_legal) begin
                        illegal = 1'b1;
                    end else if (w_j) begin
                        pcwrite  = 1'b1;
                        pcsource = 2'b10;
                    end
                end
                S_EXE: begin
                    aluc   = w_aluc;
                    aluimm = w_imm;
                    sext   = w_sext;
                    shift  = w_shift;
                    if (w_beq) begin
                        pcwrite  = zero;
                        pcsource = 2'b01;
                    end else if (w_bne) begin
                        pcwrite  = ~zero;
                        pcsource = 2'b01;
                    end
                end
                S_MEM: begin
                    iord   = 1'b1;
                    aluc   = ALU_ADD;
                    aluimm = 1'b1;
                    sext   = 1'b1;
                    wmem   = w_sw;
                end
                S_WB: begin
                    wreg  = 1'b1;
                    m2reg = w_lw;
                    regrt = ~w_rtype;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

    logic       clock, reset, zero, mem_ready;
    logic [5:0] op, func;
    logic [2:0] state;
    logic       pcwrite, irwrite, iord, wmem, wreg, m2reg, regrt, aluimm, sext, shift, illegal;
    logic [1:0] pcsource;
    logic [3:0] aluc;

    mc_control dut (
        .clock(clock), .reset(reset), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .state(state), .pcwrite(pcwrite),
        .pcsource(pcsource), .irwrite(irwrite), .iord(iord), .wmem(wmem),
        .wreg(wreg), .m2reg(m2reg), .regrt(regrt), .aluimm(aluimm),
        .sext(sext), .shift(shift), .aluc(aluc), .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] state;
        logic       pcwrite;
        logic [1:0] pcsource;
        logic       irwrite;
        logic       iord;
        logic       wmem;
        logic       wreg;
        logic       m2reg;
        logic       regrt;
        logic       aluimm;
        logic       sext;
        logic       shift;
        logic [3:0] aluc;
        logic       illegal;
    } outs_t;

    localparam int K_R = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_J = 6;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        bit         rf;
        int         kind;
        logic [3:0] aluc;
        bit         imm;
        bit         sx;
        bit         sh;
    } ent_t;

    typedef struct {
        bit         rst;
        bit         mr;
        bit         z;
        logic [5:0] op;
        logic [5:0] func;
        outs_t      exp;
        outs_t      mask;
    } step_t;

    ent_t  tbl[$];
    string tname[$];
    step_t steps[$];
    string snames[$];

    outs_t sb_exp[$];
    outs_t sb_mask[$];
    string sb_name[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int force_z = -1;

    task automatic add_e(input string n, input logic [5:0] o, input logic [5:0] f, input bit rf,
                         input int k, input logic [3:0] a, input bit im, input bit sx, input bit sh);
        ent_t e;
        e.op = o; e.func = f; e.rf = rf; e.kind = k; e.aluc = a; e.imm = im; e.sx = sx; e.sh = sh;
        tbl.push_back(e);
        tname.push_back(n);
    endtask

    function automatic int lookup(input logic [5:0] o, input logic [5:0] f);
        foreach (tbl[i]) if (tbl[i].op == o && (!tbl[i].rf || tbl[i].func == f)) return i;
        return -1;
    endfunction

    task automatic push_step(input bit rst, input bit mr, input bit z, input logic [5:0] o,
                             input logic [5:0] f, input outs_t e, input outs_t m, input string n);
        step_t s;
        s.rst = rst; s.mr = mr; s.z = z; s.op = o; s.func = f; s.exp = e; s.mask = m;
        steps.push_back(s);
        snames.push_back(n);
    endtask

    task automatic build(input logic [5:0] o, input logic [5:0] f, input int sif, input int smem);
        outs_t x;
        outs_t all;
        int    idx;
        int    kind;
        string nm;
        bit    z;
        all = '1;
        idx = lookup(o, f);
        kind = (idx >= 0) ? tbl[idx].kind : -1;
        nm = (idx >= 0) ? tname[idx] : "illegal";
        steps.delete();
        snames.delete();
        for (int k = 0; k < sif; k++) begin
            x = '0;
            push_step(1'b0, 1'b0, 1'b0, o, f, x, all, {nm, ".IF_stall"});
        end
        x = '0; x.irwrite = 1'b1; x.pcwrite = 1'b1;
        push_step(1'b0, 1'b1, 1'b0, o, f, x, all, {nm, ".IF"});
        x = '0; x.state = 3'd1;
        if (idx < 0) x.illegal = 1'b1;
        else if (kind == K_J) begin x.pcwrite = 1'b1; x.pcsource = 2'b10; end
        push_step(1'b0, $urandom_range(0, 1) != 0, 1'b0, o, f, x, all, {nm, ".ID"});
        if (idx < 0 || kind == K_J) return;
        z = (force_z >= 0) ? (force_z != 0) : ($urandom_range(0, 1) != 0);
        x = '0; x.state = 3'd2;
        x.aluc = tbl[idx].aluc; x.aluimm = tbl[idx].imm; x.sext = tbl[idx].sx; x.shift = tbl[idx].sh;
        if (kind == K_BEQ) begin x.pcwrite = z;  x.pcsource = 2'b01; end
        if (kind == K_BNE) begin x.pcwrite = !z; x.pcsource = 2'b01; end
        push_step(1'b0, $urandom_range(0, 1) != 0, z, o, f, x, all, {nm, ".EXE"});
        if (kind == K_BEQ || kind == K_BNE) return;
        if (kind == K_LW || kind == K_SW) begin
            for (int k = 0; k <= smem; k++) begin
                x = '0; x.state = 3'd3; x.iord = 1'b1; x.aluimm = 1'b1; x.sext = 1'b1;
                x.wmem = (kind == K_SW);
                push_step(1'b0, k == smem, 1'b0, o, f, x, all, {nm, ".MEM"});
            end
            if (kind == K_SW) return;
        end
        x = '0; x.state = 3'd4; x.wreg = 1'b1; x.m2reg = (kind == K_LW); x.regrt = (kind != K_R);
        push_step(1'b0, $urandom_range(0, 1) != 0, 1'b0, o, f, x, all, {nm, ".WB"});
    endtask

    task automatic issue(input step_t s, input string n);
        @(posedge clock);
        #1;
        reset = s.rst; mem_ready = s.mr; zero = s.z; op = s.op; func = s.func;
        sb_exp.push_back(s.exp);
        sb_mask.push_back(s.mask);
        sb_name.push_back(n);
    endtask

    task automatic do_reset(input int len, input logic [5:0] o, input logic [5:0] f, input string n);
        step_t s;
        for (int r = 0; r < len; r++) begin
            s.rst = 1'b1; s.mr = 1'b1; s.z = ($urandom_range(0, 1) != 0); s.op = o; s.func = f;
            s.exp = '0; s.mask = '1;
            if (r == 0) s.mask.state = 3'b000;
            issue(s, {n, ".reset"});
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int sif,
                             input int smem, input int rst_at, input int rst_len);
        int ra;
        build(o, f, sif, smem);
        ra = rst_at;
        if (ra == -2) ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, steps.size() - 1) : -1;
        foreach (steps[i]) begin
            if (i == ra) begin
                do_reset(rst_len, o, f, snames[i]);
                break;
            end
            issue(steps[i], snames[i]);
        end
    endtask

    initial begin : monitor
        outs_t act, e, m;
        string n;
        forever begin
            @(negedge clock);
            if (sb_exp.size() > 0) begin
                e = sb_exp.pop_front();
                m = sb_mask.pop_front();
                n = sb_name.pop_front();
                act.state = state; act.pcwrite = pcwrite; act.pcsource = pcsource;
                act.irwrite = irwrite; act.iord = iord; act.wmem = wmem; act.wreg = wreg;
                act.m2reg = m2reg; act.regrt = regrt; act.aluimm = aluimm; act.sext = sext;
                act.shift = shift; act.aluc = aluc; act.illegal = illegal;
                n_cmp++;
                if ((act & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL %s @%0t: actual %b required %b (mask %b)", n, $time, act, e, m);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual running required done");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [5:0] ro, rf;
        int         idx;
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = 6'd0; func = 6'd0;

        add_e("add",  6'b000000, 6'b100000, 1, K_R, 4'b0000, 0, 0, 0);
        add_e("sub",  6'b000000, 6'b100010, 1, K_R, 4'b0100, 0, 0, 0);
        add_e("and",  6'b000000, 6'b100100, 1, K_R, 4'b0001, 0, 0, 0);
        add_e("or",   6'b000000, 6'b100101, 1, K_R, 4'b0101, 0, 0, 0);
        add_e("xor",  6'b000000, 6'b100110, 1, K_R, 4'b0010, 0, 0, 0);
        add_e("sll",  6'b000000, 6'b000000, 1, K_R, 4'b0011, 0, 0, 1);
        add_e("srl",  6'b000000, 6'b000010, 1, K_R, 4'b0111, 0, 0, 1);
        add_e("sra",  6'b000000, 6'b000011, 1, K_R, 4'b1111, 0, 0, 1);
        add_e("hamd", 6'b000000, 6'b111111, 1, K_R, 4'b1011, 0, 0, 0);
        add_e("addi", 6'b001000, 6'b000000, 0, K_IALU, 4'b0000, 1, 1, 0);
        add_e("andi", 6'b001100, 6'b000000, 0, K_IALU, 4'b0001, 1, 0, 0);
        add_e("ori",  6'b001101, 6'b000000, 0, K_IALU, 4'b0101, 1, 0, 0);
        add_e("xori", 6'b001110, 6'b000000, 0, K_IALU, 4'b0010, 1, 0, 0);
        add_e("lui",  6'b001111, 6'b000000, 0, K_IALU, 4'b0110, 1, 0, 0);
        add_e("lw",   6'b100011, 6'b000000, 0, K_LW, 4'b0000, 1, 1, 0);
        add_e("sw",   6'b101011, 6'b000000, 0, K_SW, 4'b0000, 1, 1, 0);
        add_e("beq",  6'b000100, 6'b000000, 0, K_BEQ, 4'b0100, 0, 0, 0);
        add_e("bne",  6'b000101, 6'b000000, 0, K_BNE, 4'b0100, 0, 0, 0);
        add_e("j",    6'b000010, 6'b000000, 0, K_J, 4'b0000, 0, 0, 0);

        do_reset(2, 6'd0, 6'd0, "powerup");

        run_instr(6'b000000, 6'b100000, 0, 0, -1, 0);
        run_instr(6'b100011, 6'b010101, 2, 3, -1, 0);
        force_z = 1;
        run_instr(6'b000100, 6'b000000, 0, 0, -1, 0);
        run_instr(6'b000101, 6'b000000, 0, 0, -1, 0);
        force_z = -1;
        run_instr(6'b000000, 6'b000011, 0, 0, -1, 0);
        run_instr(6'b000000, 6'b111111, 1, 0, -1, 0);
        run_instr(6'b001111, 6'b000000, 0, 0, -1, 0);
        run_instr(6'b001100, 6'b000000, 0, 0, -1, 0);
        run_instr(6'b111111, 6'b000000, 0, 0, -1, 0);
        run_instr(6'b000010, 6'b000000, 0, 0, -1, 0);
        run_instr(6'b101011, 6'b000000, 0, 2, 4, 2);
        run_instr(6'b101011, 6'b000000, 1, 2, -1, 0);

        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 6) == 0) begin
                ro = 6'($urandom);
                rf = 6'($urandom);
                if ($urandom_range(0, 1) == 0) ro = 6'd0;
            end else begin
                idx = $urandom_range(0, tbl.size() - 1);
                ro = tbl[idx].op;
                rf = tbl[idx].rf ? tbl[idx].func : 6'($urandom);
            end
            run_instr(ro, rf, $urandom_range(0, 3), $urandom_range(0, 3), -2, $urandom_range(1, 3));
        end

        @(negedge clock);
        #1;
        if (n_cmp < 500) begin
            n_fail++;
            $display("FAIL coverage: actual %0d compared cycles required at least 500", n_cmp);
        end
        if (n_fail != 0)
            $display("FAIL result: actual %0d mismatches required 0", n_fail);
        else
            $display("PASS: all cycles matched");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
